// File: rtl/mips_cpu_mem_access_unit.sv
// mips_cpu_mem_access_unit
//   Load/store bus master for the multicycle MIPS core. It takes one
//   byte/half/word request at a time and runs it as a single Avalon-MM
//   transaction. It builds the byte lanes and store data, and extracts and
//   extends load data. Misaligned or illegal-size requests are rejected
//   without a bus cycle. A bus cycle that stalls for too long is aborted
//   with an error.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_*                 CPU request (valid/ready handshake, write, size,
//                         signed, byte address, right-justified store data)
//   resp_valid/rdata/err  one-cycle completion pulse, extended load data,
//                         error flag
//   mem_*, memread,       Avalon-MM master (word-aligned address, strobes,
//   memwrite, byteenable, lane-replicated store data, stall, read data)
//   waitrequest

module mips_cpu_mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              memread,
  output logic              memwrite,
  input  logic              waitrequest,
  output logic [31:0]       memwritedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       memreaddata
);

  // state | meaning
  // IDLE  | ready for a request
  // BUS   | Avalon transaction in flight, waiting for waitrequest low
  // RESP  | resp_valid pulse, then back to IDLE
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUS  = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The counter only needs to reach TIMEOUT-1; the abort fires on the
  // cycle it sits there with waitrequest still high.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic             write_q;

  logic             misaligned;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [1:0]       byte_idx;
  logic             half_hi;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_ext;
  logic             timeout_hit;

  // The reset term keeps req_ready low until reset is released.
  assign req_ready = (state == IDLE) && !reset;

  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  always_comb begin
    be_next    = 4'b0000;
    wdata_next = req_wdata;
    case (req_size)
      SZ_WORD: begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
      SZ_HALF: begin
        if (BIG_ENDIAN) be_next = req_addr[1] ? 4'b0011 : 4'b1100;
        else            be_next = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        if (BIG_ENDIAN) be_next = 4'b0001 << (2'd3 - req_addr[1:0]);
        else            be_next = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
    endcase
  end

  // Load lane selection uses the offset latched at accept time.
  always_comb begin
    byte_idx = BIG_ENDIAN ? (2'd3 - off_q) : off_q;
    half_hi  = BIG_ENDIAN ? ~off_q[1] : off_q[1];
    case (byte_idx)
      2'd0:    ld_byte = memreaddata[7:0];
      2'd1:    ld_byte = memreaddata[15:8];
      2'd2:    ld_byte = memreaddata[23:16];
      default: ld_byte = memreaddata[31:24];
    endcase
    ld_half = half_hi ? memreaddata[31:16] : memreaddata[15:0];
    case (size_q)
      SZ_BYTE: load_ext = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      SZ_HALF: load_ext = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: load_ext = memreaddata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt_q        <= '0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_err     <= 1'b0;
      mem_address  <= '0;
      memread      <= 1'b0;
      memwrite     <= 1'b0;
      memwritedata <= 32'h0;
      byteenable   <= 4'b0000;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              mem_address  <= {req_addr[ADDR_W-1:2], 2'b00};
              byteenable   <= be_next;
              memwritedata <= wdata_next;
              memwrite     <= req_write;
              memread      <= !req_write;
              off_q        <= req_addr[1:0];
              size_q       <= req_size;
              signed_q     <= req_signed;
              write_q      <= req_write;
              cnt_q        <= '0;
              state        <= BUS;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_q ? 32'h0 : load_ext;
            state      <= RESP;
          end else if (timeout_hit) begin
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
            state      <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_access_unit.sv
// tb_mips_cpu_mem_access_unit
//   Directed bench for mips_cpu_mem_access_unit. Two instances share the
//   inputs: dut is big-endian, dut_le is little-endian; both use TIMEOUT=4.

module tb_mips_cpu_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        waitrequest;
  logic [31:0] memreaddata;

  logic        req_ready, resp_valid, resp_err, memread, memwrite;
  logic [31:0] resp_rdata, mem_address, memwritedata;
  logic [3:0]  byteenable;

  logic        le_req_ready, le_resp_valid, le_resp_err, le_memread, le_memwrite;
  logic [31:0] le_resp_rdata, le_mem_address, le_memwritedata;
  logic [3:0]  le_byteenable;

  int checks = 0;
  int errors = 0;

  mips_cpu_mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .memread(memread), .memwrite(memwrite),
    .waitrequest(waitrequest), .memwritedata(memwritedata),
    .byteenable(byteenable), .memreaddata(memreaddata)
  );

  mips_cpu_mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(4)) dut_le (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(le_req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(le_resp_valid), .resp_rdata(le_resp_rdata), .resp_err(le_resp_err),
    .mem_address(le_mem_address), .memread(le_memread), .memwrite(le_memwrite),
    .waitrequest(waitrequest), .memwritedata(le_memwritedata),
    .byteenable(le_byteenable), .memreaddata(memreaddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({memread, memwrite, resp_valid, resp_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {memread, memwrite, resp_valid, resp_err});
    end
    checks++;
    if ({mem_address, memwritedata, resp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h exp 0", mem_address, memwritedata, resp_rdata);
    end
    checks++;
    if (byteenable !== 4'b0000) begin
      errors++;
      $display("FAIL reset_be got %b exp 0000", byteenable);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw;
    waitrequest = 1'b0;
    memreaddata = 32'hDEADBEEF;
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if ({memread, memwrite, resp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL lw_strobe got %b exp 100", {memread, memwrite, resp_valid});
    end
    checks++;
    if (mem_address !== 32'h100 || byteenable !== 4'b1111) begin
      errors++;
      $display("FAIL lw_addr_be got %h %b exp 00000100 1111", mem_address, byteenable);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_err, memread} !== 3'b100 || resp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_resp got v/e/rd=%b rdata=%h exp 100 deadbeef",
               {resp_valid, resp_err, memread}, resp_rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_after got v=%b rdy=%b rdata=%h exp 0 1 deadbeef",
               resp_valid, req_ready, resp_rdata);
    end
  endtask

  task automatic test_load_lanes;
    logic [1:0]  sz  [3] = '{2'b00, 2'b01, 2'b00};
    logic        sg  [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] ad  [3] = '{32'h103, 32'h102, 32'h100};
    logic [31:0] md  [3] = '{32'h11223380, 32'h1122B380, 32'h11223380};
    logic [3:0]  ebe [3] = '{4'b0001, 4'b0011, 4'b1000};
    logic [3:0]  ele [3] = '{4'b1000, 4'b1100, 4'b0001};
    logic [31:0] rbe [3] = '{32'hFFFFFF80, 32'hFFFFB380, 32'h00000011};
    logic [31:0] rle [3] = '{32'h00000011, 32'h00001122, 32'h00000080};
    waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      memreaddata = md[i];
      drive_req(1'b0, sz[i], sg[i], ad[i], 32'h0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checks++;
      if (byteenable !== ebe[i] || le_byteenable !== ele[i]) begin
        errors++;
        $display("FAIL ld_be[%0d] got be=%b le=%b exp be=%b le=%b",
                 i, byteenable, le_byteenable, ebe[i], ele[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== rbe[i] || le_resp_rdata !== rle[i]) begin
        errors++;
        $display("FAIL ld_rdata[%0d] got v=%b be=%h le=%h exp 1 %h %h",
                 i, resp_valid, resp_rdata, le_resp_rdata, rbe[i], rle[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sh_wait;
    waitrequest = 1'b1;
    drive_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({memwrite, memread, resp_valid} !== 3'b100 || mem_address !== 32'h200 ||
          memwritedata !== 32'hABCDABCD || byteenable !== 4'b0011 ||
          le_byteenable !== 4'b1100) begin
        errors++;
        $display("FAIL sh_hold[%0d] got w/r/v=%b addr=%h data=%h be=%b le=%b exp 100 00000200 abcdabcd 0011 1100",
                 i, {memwrite, memread, resp_valid}, mem_address, memwritedata,
                 byteenable, le_byteenable);
      end
      if (i == 3) waitrequest = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if ({resp_valid, resp_err, memwrite} !== 3'b100 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL sh_resp got v/e/w=%b rdata=%h exp 100 00000000",
               {resp_valid, resp_err, memwrite}, resp_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sb;
    waitrequest = 1'b0;
    drive_req(1'b1, 2'b00, 1'b0, 32'h001, 32'h12345677);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if ({memwrite, memread} !== 2'b10 || memwritedata !== 32'h77777777 ||
        le_memwritedata !== 32'h77777777) begin
      errors++;
      $display("FAIL sb_data got w/r=%b data=%h le=%h exp 10 77777777",
               {memwrite, memread}, memwritedata, le_memwritedata);
    end
    checks++;
    if (byteenable !== 4'b0100 || le_byteenable !== 4'b0010) begin
      errors++;
      $display("FAIL sb_be got be=%b le=%b exp 0100 0010", byteenable, le_byteenable);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_misaligned;
    logic       wr [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] sz [3] = '{2'b01, 2'b11, 2'b10};
    logic [31:0] ad [3] = '{32'h101, 32'h100, 32'h102};
    waitrequest = 1'b0;
    memreaddata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      drive_req(wr[i], sz[i], 1'b1, ad[i], 32'h12345678);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checks++;
      if ({memread, memwrite, resp_valid, resp_err} !== 4'b0011 || resp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL misalign[%0d] got r/w/v/e=%b rdata=%h exp 0011 00000000",
                 i, {memread, memwrite, resp_valid, resp_err}, resp_rdata);
      end
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || memread !== 1'b0) begin
        errors++;
        $display("FAIL misalign_after[%0d] got v=%b rdy=%b rd=%b exp 0 1 0",
                 i, resp_valid, req_ready, memread);
      end
    end
  endtask

  task automatic test_timeout;
    waitrequest = 1'b1;
    drive_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (memread !== 1'b1 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL to_hold[%0d] got rd=%b v=%b exp 1 0", i, memread, resp_valid);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if ({memread, resp_valid, resp_err} !== 3'b011 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_abort got rd/v/e=%b rdata=%h exp 011 00000000",
               {memread, resp_valid, resp_err}, resp_rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b1) begin
      errors++;
      $display("FAIL to_idle got rdy=%b v=%b e=%b exp 1 0 1", req_ready, resp_valid, resp_err);
    end
    waitrequest = 1'b0;
    memreaddata = 32'hCAFEF00D;
    drive_req(1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (memread !== 1'b1 || mem_address !== 32'h304) begin
      errors++;
      $display("FAIL to_next_req got rd=%b addr=%h exp 1 00000304", memread, mem_address);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL to_next_resp got v/e=%b rdata=%h exp 10 cafef00d",
               {resp_valid, resp_err}, resp_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_bus;
    waitrequest = 1'b1;
    drive_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (memread !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got rd=%b exp 1", memread);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (memread !== 1'b0 || mem_address !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_async got rd=%b addr=%h exp 0 00000000", memread, mem_address);
    end
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle got rdy=%b v=%b exp 1 0", req_ready, resp_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || memread !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stay got rdy=%b rd=%b exp 1 0", req_ready, memread);
    end
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'b00;
    req_signed  = 1'b0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    waitrequest = 1'b0;
    memreaddata = 32'h0;
    test_reset();
    test_lw();
    test_load_lanes();
    test_sh_wait();
    test_sb();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
